// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: branch encodings, default widths,
// and the hard-wired zero register index.
package mips_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RB_DEF   = 5;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_BEQ  = 2'b01;
    localparam logic [1:0] BR_BNE  = 2'b10;
    localparam logic [1:0] BR_JR   = 2'b11;

    // Register 0 reads as zero and is never a forwarding target.
    localparam logic [RB_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/id_issue_stage_fwd_select.sv
// Operand forwarding select for one source register index. The lowest-index
// (youngest) valid source with a matching destination wins; if that source
// has no data yet the operand is reported as stalled.
module fwd_select
    import mips_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RB      = RB_DEF,
    parameter int NUM_FWD = 3
) (
    input  logic [RB-1:0]           i_idx,
    input  logic [XLEN-1:0]         i_q,
    input  logic [NUM_FWD-1:0]      i_fwd_valid,
    input  logic [NUM_FWD*RB-1:0]   i_fwd_reg,
    input  logic [NUM_FWD-1:0]      i_fwd_rdy,
    input  logic [NUM_FWD*XLEN-1:0] i_fwd_data,
    output logic [XLEN-1:0]         o_data,
    output logic                    o_match,
    output logic                    o_stall
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        o_data  = i_q;
        o_match = 1'b0;
        o_stall = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (i_fwd_valid[i] && (i_fwd_reg[i*RB +: RB] == i_idx)) begin
                o_data  = i_fwd_data[i*XLEN +: XLEN];
                o_match = 1'b1;
                o_stall = !i_fwd_rdy[i];
            end
        end
        if (i_idx == RB'(REG_ZERO)) begin
            o_data  = '0;
            o_match = 1'b0;
            o_stall = 1'b0;
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// Operand-read / issue stage: forwards operands from in-flight results,
// detects load-use hazards, resolves branches and jr early, and holds the
// ID/EX register behind a valid/ready handshake.
module id_issue_stage
    import mips_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RB      = RB_DEF,
    parameter int NUM_FWD = 3,
    parameter int CTRL_W  = 31,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [RB-1:0]           in_rs,
    input  logic [RB-1:0]           in_rt,
    input  logic [RB-1:0]           in_rn,
    input  logic                    in_wr,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [1:0]              in_br,
    input  logic [XLEN-1:0]         in_bpc,
    input  logic [XLEN-1:0]         qa,
    input  logic [XLEN-1:0]         qb,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD*RB-1:0]   fwd_reg,
    input  logic [NUM_FWD-1:0]      fwd_rdy,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_da,
    output logic [XLEN-1:0]         out_db,
    output logic [RB-1:0]           out_rn,
    output logic                    out_wr,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic [CNT_W-1:0]        stall_cnt
);

    logic [XLEN-1:0]   w_da, w_db;
    logic              w_match_a, w_match_b;
    logic              w_stall_a, w_stall_b;
    logic              w_hazard, w_can_issue, w_issue, w_taken;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc, r_da, r_db;
    logic [RB-1:0]     r_rn;
    logic              r_wr;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    fwd_select #(.XLEN(XLEN), .RB(RB), .NUM_FWD(NUM_FWD)) u_fwd_a (
        .i_idx(in_rs), .i_q(qa),
        .i_fwd_valid(fwd_valid), .i_fwd_reg(fwd_reg),
        .i_fwd_rdy(fwd_rdy), .i_fwd_data(fwd_data),
        .o_data(w_da), .o_match(w_match_a), .o_stall(w_stall_a)
    );

    fwd_select #(.XLEN(XLEN), .RB(RB), .NUM_FWD(NUM_FWD)) u_fwd_b (
        .i_idx(in_rt), .i_q(qb),
        .i_fwd_valid(fwd_valid), .i_fwd_reg(fwd_reg),
        .i_fwd_rdy(fwd_rdy), .i_fwd_data(fwd_data),
        .o_data(w_db), .o_match(w_match_b), .o_stall(w_stall_b)
    );

    assign w_hazard    = w_stall_a | w_stall_b;
    assign w_can_issue = !w_hazard && !flush && (!r_valid || out_ready);
    assign w_issue     = in_valid && w_can_issue;
    assign in_ready    = w_can_issue;

    // Early branch resolution on the forwarded operands.
    always_comb begin
        w_taken     = 1'b0;
        redirect_pc = in_bpc;
        case (in_br)
            BR_BEQ:  w_taken = (w_da == w_db);
            BR_BNE:  w_taken = (w_da != w_db);
            BR_JR: begin
                w_taken     = 1'b1;
                redirect_pc = w_da;
            end
            default: w_taken = 1'b0;
        endcase
    end

    assign redirect_valid = w_issue && w_taken;

    // ID/EX register: flush kills, issue loads, a consumed entry drains.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_da    <= '0;
            r_db    <= '0;
            r_rn    <= '0;
            r_wr    <= 1'b0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_issue) begin
            r_valid <= 1'b1;
            r_pc    <= in_pc;
            r_da    <= w_da;
            r_db    <= w_db;
            r_rn    <= in_rn;
            r_wr    <= in_wr;
            r_ctrl  <= in_ctrl;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Count consecutive hazard-stall cycles, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_issue || flush) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign out_da    = r_da;
    assign out_db    = r_db;
    assign out_rn    = r_rn;
    assign out_wr    = r_wr;
    assign out_ctrl  = r_ctrl;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: forwarding priority, load-use stall,
// branch resolve, back-pressure, flush, register zero and async reset.
module tb_id_issue_stage;

    localparam int XLEN = 32, RB = 5, NF = 3, CW = 31, CNT = 16;

    logic clk, reset;
    logic in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_bpc, qa, qb;
    logic [RB-1:0] in_rs, in_rt, in_rn;
    logic in_wr, flush, out_valid, out_ready, out_wr, redirect_valid;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [1:0] in_br;
    logic [NF-1:0] fwd_valid, fwd_rdy;
    logic [NF*RB-1:0] fwd_reg;
    logic [NF*XLEN-1:0] fwd_data;
    logic [XLEN-1:0] out_pc, out_da, out_db, redirect_pc;
    logic [RB-1:0] out_rn;
    logic [CNT-1:0] stall_cnt;

    int n_pass = 0, n_total = 0;

    id_issue_stage #(.XLEN(XLEN), .RB(RB), .NUM_FWD(NF), .CTRL_W(CW), .CNT_W(CNT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_rn(in_rn), .in_wr(in_wr),
        .in_ctrl(in_ctrl), .in_br(in_br), .in_bpc(in_bpc), .qa(qa), .qb(qb),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_rdy(fwd_rdy), .fwd_data(fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_da(out_da), .out_db(out_db), .out_rn(out_rn),
        .out_wr(out_wr), .out_ctrl(out_ctrl), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 0; in_pc = '0; in_rs = '0; in_rt = '0; in_rn = '0;
        in_wr = 0; in_ctrl = '0; in_br = 2'b00; in_bpc = '0; qa = '0; qb = '0;
        fwd_valid = '0; fwd_reg = '0; fwd_rdy = '0; fwd_data = '0;
        flush = 0; out_ready = 0;
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_out_pc", 64'(out_pc), 64'd0);
        chk("rst_redirect", 64'(redirect_valid), 64'd0);
        reset = 1'b0;

        // No hazards: add r3,r1,r2 back to back
        in_valid = 1; in_rs = 5'd1; in_rt = 5'd2; in_rn = 5'd3; in_wr = 1;
        in_ctrl = 31'h155; qa = 32'd5; qb = 32'd7; in_pc = 32'h100; out_ready = 1;
        #1 chk("nh_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("nh_valid", 64'(out_valid), 64'd1);
        chk("nh_da", 64'(out_da), 64'd5);
        chk("nh_db", 64'(out_db), 64'd7);
        chk("nh_pc", 64'(out_pc), 64'h100);
        chk("nh_rn", 64'(out_rn), 64'd3);
        chk("nh_ctrl", 64'(out_ctrl), 64'h155);
        in_pc = 32'h104;
        #1 chk("nh_in_ready2", 64'(in_ready), 64'd1);
        tick();
        chk("nh_pc2", 64'(out_pc), 64'h104);
        chk("nh_stall", 64'(stall_cnt), 64'd0);

        // Forwarding priority
        in_rs = 5'd4; fwd_valid = 3'b111; fwd_rdy = 3'b111;
        fwd_reg = {5'd4, 5'd4, 5'd4};
        fwd_data = {32'h33, 32'h22, 32'h11};
        tick();
        chk("pri_src0", 64'(out_da), 64'h11);
        chk("pri_db_reg", 64'(out_db), 64'd7);
        fwd_valid = 3'b110;
        tick();
        chk("pri_src1", 64'(out_da), 64'h22);

        // Load-use stall
        in_rs = 5'd8; fwd_valid = 3'b001; fwd_rdy = 3'b000;
        fwd_reg = {5'd0, 5'd0, 5'd8};
        #1 chk("lu_in_ready", 64'(in_ready), 64'd0);
        chk("lu_no_redirect", 64'(redirect_valid), 64'd0);
        tick();
        chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
        chk("lu_drained", 64'(out_valid), 64'd0);
        fwd_valid = 3'b010; fwd_rdy = 3'b010;
        fwd_reg = {5'd0, 5'd8, 5'd0};
        fwd_data = {32'h0, 32'hAB, 32'h0};
        #1 chk("lu_in_ready2", 64'(in_ready), 64'd1);
        tick();
        chk("lu_da", 64'(out_da), 64'hAB);
        chk("lu_valid", 64'(out_valid), 64'd1);
        chk("lu_stall_clr", 64'(stall_cnt), 64'd0);

        // Branch resolve
        in_rs = 5'd1; in_rt = 5'd2; fwd_valid = 3'b011; fwd_rdy = 3'b011;
        fwd_reg = {5'd0, 5'd2, 5'd1};
        fwd_data = {32'h0, 32'h40, 32'h40};
        in_br = 2'b01; in_bpc = 32'h1000;
        #1 chk("beq_valid", 64'(redirect_valid), 64'd1);
        chk("beq_pc", 64'(redirect_pc), 64'h1000);
        tick();
        in_br = 2'b00;
        #1 chk("beq_one_cycle", 64'(redirect_valid), 64'd0);
        in_br = 2'b10;
        #1 chk("bne_not_taken", 64'(redirect_valid), 64'd0);
        in_br = 2'b11; fwd_data = {32'h0, 32'h40, 32'h2000};
        #1 chk("jr_valid", 64'(redirect_valid), 64'd1);
        chk("jr_pc", 64'(redirect_pc), 64'h2000);
        tick();
        in_br = 2'b00;

        // Back-pressure
        fwd_valid = 3'b000; in_pc = 32'h200;
        tick();
        chk("bp_pc0", 64'(out_pc), 64'h200);
        out_ready = 0; in_pc = 32'h204; in_br = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_no_redirect", 64'(redirect_valid), 64'd0);
            tick();
            chk("bp_pc_hold", 64'(out_pc), 64'h200);
            chk("bp_valid_hold", 64'(out_valid), 64'd1);
        end
        in_br = 2'b00; out_ready = 1;
        #1 chk("bp_release", 64'(in_ready), 64'd1);
        tick();
        chk("bp_replace", 64'(out_pc), 64'h204);
        chk("bp_replace_v", 64'(out_valid), 64'd1);

        // Flush
        flush = 1; in_pc = 32'h208; in_br = 2'b11;
        #1 chk("fl_in_ready", 64'(in_ready), 64'd0);
        chk("fl_no_redirect", 64'(redirect_valid), 64'd0);
        tick();
        chk("fl_valid", 64'(out_valid), 64'd0);
        flush = 0; in_br = 2'b00;

        // Register zero never stalls and reads zero
        in_rs = 5'd0; qa = 32'h55; fwd_valid = 3'b001; fwd_rdy = 3'b000;
        fwd_reg = {5'd0, 5'd0, 5'd0}; in_pc = 32'h300;
        #1 chk("r0_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("r0_da", 64'(out_da), 64'd0);
        chk("r0_db", 64'(out_db), 64'd7);
        chk("r0_stall", 64'(stall_cnt), 64'd0);

        // Async reset mid-stall with a held entry
        out_ready = 0; in_rs = 5'd8; fwd_reg = {5'd0, 5'd0, 5'd8};
        tick(); tick();
        chk("ar_stall2", 64'(stall_cnt), 64'd2);
        chk("ar_held", 64'(out_valid), 64'd1);
        #2 reset = 1'b1;
        #1 chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_stall", 64'(stall_cnt), 64'd0);
        chk("ar_pc", 64'(out_pc), 64'd0);
        tick();
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
